// File: rtl/itcm_autoload_axi_rd_if.sv
// Signal bundle between the ITCM auto-load port, the read initiator and the
// external AXI read channels (AR/R only).
interface itcm_autoload_axi_rd_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  itcm_auto_load;
  logic                  itcm_access_AXI;
  logic [ADDR_WIDTH-1:0] itcm_auto_load_addr;
  logic                  IAXI_ready;
  logic [DATA_WIDTH-1:0] IAXI_read_data;
  logic                  IAXI_read_data_valid;

  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [ID_WIDTH-1:0]   ARID;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic [ID_WIDTH-1:0]   RID;

  modport master (
    input  itcm_auto_load, itcm_access_AXI, itcm_auto_load_addr,
    output IAXI_ready, IAXI_read_data, IAXI_read_data_valid,
    output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST,
    input  ARREADY,
    input  RVALID, RDATA, RRESP, RLAST, RID,
    output RREADY
  );

  modport slave (
    output itcm_auto_load, itcm_access_AXI, itcm_auto_load_addr,
    input  IAXI_ready, IAXI_read_data, IAXI_read_data_valid,
    input  ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST,
    output ARREADY,
    output RVALID, RDATA, RRESP, RLAST, RID,
    input  RREADY
  );
endinterface

// File: rtl/itcm_autoload_axi_rd.sv
// Single-beat AXI4 read initiator serving the ITCM's word-by-word auto-load
// requests: one outstanding read, ITCM address remapped onto the boot image.
module itcm_autoload_axi_rd #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0]   AXI_ID     = '0,
  parameter logic [ADDR_WIDTH-1:0] ITCM_BASE  = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] SRC_BASE   = 32'h2000_0000
) (
  input  logic                          clk,
  input  logic                          rstn,
  itcm_autoload_axi_rd_if.master        bus,
  output logic                          load_err,
  output logic [15:0]                   load_words
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                r_state, w_state_n;
  logic                  r_ready, w_ready_n;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_accept, w_beat, w_beat_err;
  logic                  w_arvalid, w_rready, w_rd_vld;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Rebase onto the boot image (wraps modulo 2^ADDR_WIDTH), word aligned.
  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] t;
    t      = a - ITCM_BASE + SRC_BASE;
    t[1:0] = 2'b00;
    return t;
  endfunction

  assign w_accept   = (r_state == S_IDLE) && bus.itcm_access_AXI && r_ready;
  assign w_beat     = (r_state == S_DATA) && bus.RVALID;
  assign w_beat_err = (bus.RRESP != 2'b00) || !bus.RLAST || (bus.RID != AXI_ID);

  always_comb begin
    w_state_n = r_state;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    w_rd_vld  = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_n = S_ADDR;
      S_ADDR: begin
        w_arvalid = 1'b1;
        if (bus.ARREADY) w_state_n = S_DATA;
      end
      S_DATA: begin
        w_rready = 1'b1;
        if (bus.RVALID) w_state_n = S_RESP;
      end
      S_RESP: begin
        w_rd_vld  = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    // Ready is offered only once the FSM is back in IDLE inside the window.
    w_ready_n = (w_state_n == S_IDLE) && bus.itcm_auto_load;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_araddr   <= '0;
      r_rdata    <= '0;
      load_err   <= 1'b0;
      load_words <= '0;
    end else begin
      r_state <= w_state_n;
      r_ready <= w_ready_n;
      if (w_accept) r_araddr <= map_addr(bus.itcm_auto_load_addr);
      if (w_beat) begin
        r_rdata <= bus.RDATA;
        if (w_beat_err) load_err <= 1'b1;
      end
      if (r_state == S_RESP) load_words <= sat_inc16(load_words);
    end
  end

  assign bus.IAXI_ready           = r_ready;
  assign bus.IAXI_read_data       = r_rdata;
  assign bus.IAXI_read_data_valid = w_rd_vld;
  assign bus.ARVALID              = w_arvalid;
  assign bus.ARADDR               = r_araddr;
  assign bus.ARID                 = AXI_ID;
  assign bus.ARLEN                = 8'd0;
  assign bus.ARSIZE               = 3'b010;
  assign bus.ARBURST              = 2'b01;
  assign bus.RREADY               = w_rready;

endmodule

// File: tb/tb_itcm_autoload_axi_rd.sv
// Directed bench for itcm_autoload_axi_rd: inputs change and outputs are
// observed on the falling clock edge.
module tb_itcm_autoload_axi_rd;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load_err;
  logic [15:0] load_words;
  int          n_cmp = 0;
  int          n_bad = 0;

  int ar_tab [8] = '{0, 2, 1, 3, 0, 1, 2, 0};
  int r_tab  [8] = '{0, 1, 3, 0, 2, 0, 1, 2};

  itcm_autoload_axi_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  itcm_autoload_axi_rd dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .load_err   (load_err),
    .load_words (load_words)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.itcm_access_AXI     = 1'b0;
    bus.itcm_auto_load_addr = '0;
    bus.ARREADY             = 1'b0;
    bus.RVALID              = 1'b0;
    bus.RDATA               = '0;
    bus.RRESP               = 2'b00;
    bus.RLAST               = 1'b1;
    bus.RID                 = 4'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    bus.itcm_auto_load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Drives one request and answers AR/R with the given delays; reports what it saw.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] data,
                      input int ar_dly, input int r_dly, input logic [1:0] resp,
                      input logic last, input logic [3:0] rid, input bit drop_win,
                      output logic [31:0] araddr_o, output int lat, output int pulses,
                      output logic [31:0] rd_o, output bit ar_stable,
                      output int ready_busy, output bit ready_end, output bit tmo);
    int ar_cnt, r_cnt, k, pk;
    bit seen;
    ar_cnt = 0; r_cnt = 0; pk = 0; seen = 0;
    araddr_o = '0; lat = 0; pulses = 0; rd_o = '0; ar_stable = 1;
    ready_busy = 0; ready_end = 0; tmo = 0;
    bus.itcm_auto_load_addr = addr;
    bus.itcm_access_AXI     = 1'b1;
    @(negedge clk);
    bus.itcm_access_AXI = 1'b0;
    k = 1;
    while (1) begin
      if (pk != 0 && k == pk + 1) begin
        ready_end = bus.IAXI_ready;
        if (bus.IAXI_read_data_valid) pulses++;
        break;
      end
      if (k > 80) begin tmo = 1; break; end
      if (bus.IAXI_ready) ready_busy++;
      if (bus.ARVALID) begin
        if (!seen) begin araddr_o = bus.ARADDR; seen = 1; end
        else if (bus.ARADDR !== araddr_o) ar_stable = 0;
        bus.ARREADY = (ar_cnt >= ar_dly);
        ar_cnt++;
      end else bus.ARREADY = 1'b0;
      if (bus.RREADY) begin
        if (drop_win) bus.itcm_auto_load = 1'b0;
        bus.RVALID = (r_cnt >= r_dly);
        bus.RDATA  = data;
        bus.RRESP  = resp;
        bus.RLAST  = last;
        bus.RID    = rid;
        r_cnt++;
      end else begin
        bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00; bus.RLAST = 1'b1; bus.RID = 4'h0;
      end
      if (bus.IAXI_read_data_valid) begin
        pulses++;
        if (pk == 0) begin pk = k; lat = k; rd_o = bus.IAXI_read_data; end
      end
      @(negedge clk);
      k++;
    end
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    bus.itcm_auto_load = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ARVALID !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid got=%b exp=0", bus.ARVALID); end
    n_cmp++; if (bus.RREADY !== 1'b0) begin n_bad++; $display("FAIL rst_rready got=%b exp=0", bus.RREADY); end
    n_cmp++; if (bus.IAXI_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", bus.IAXI_ready); end
    n_cmp++; if (bus.IAXI_read_data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_vld got=%b exp=0", bus.IAXI_read_data_valid); end
    n_cmp++; if (bus.IAXI_read_data !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", bus.IAXI_read_data); end
    n_cmp++; if (bus.ARADDR !== 32'h0) begin n_bad++; $display("FAIL rst_araddr got=%h exp=0", bus.ARADDR); end
    n_cmp++; if (load_err !== 1'b0 || load_words !== 16'd0) begin n_bad++; $display("FAIL rst_counters got=%b/%0d exp=0/0", load_err, load_words); end
    rstn = 1'b1;
    bus.itcm_access_AXI = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.IAXI_ready !== 1'b0 || bus.ARVALID !== 1'b0 || bus.RREADY !== 1'b0)
      begin n_bad++; $display("FAIL quiescent got=rdy%b arv%b rr%b exp=000", bus.IAXI_ready, bus.ARVALID, bus.RREADY); end
    bus.itcm_access_AXI = 1'b0;
    bus.itcm_auto_load  = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.IAXI_ready !== 1'b1) begin n_bad++; $display("FAIL ready_in_window got=%b exp=1", bus.IAXI_ready); end
  endtask

  task automatic test_single();
    logic [31:0] a, rd; int lat, pul, busy; bit st, re, tmo;
    apply_reset();
    fork
      begin
        @(negedge clk);
        n_cmp++; if (bus.ARLEN !== 8'd0 || bus.ARSIZE !== 3'b010 || bus.ARBURST !== 2'b01 || bus.ARID !== 4'h0)
          begin n_bad++; $display("FAIL ar_consts got=%h/%b/%b/%h exp=00/010/01/0", bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.ARID); end
      end
      xfer(32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 2'b00, 1'b1, 4'h0, 0, a, lat, pul, rd, st, busy, re, tmo);
    join
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL single_timeout got=timeout exp=pulse"); end
    n_cmp++; if (a !== 32'h2000_0010) begin n_bad++; $display("FAIL single_araddr got=%h exp=20000010", a); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL single_latency got=%0d exp=3", lat); end
    n_cmp++; if (pul !== 1) begin n_bad++; $display("FAIL single_pulses got=%0d exp=1", pul); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_rdata got=%h exp=deadbeef", rd); end
    n_cmp++; if (re !== 1'b1 || busy !== 0) begin n_bad++; $display("FAIL single_ready got=end%b busy%0d exp=end1 busy0", re, busy); end
    n_cmp++; if (load_words !== 16'd1 || load_err !== 1'b0) begin n_bad++; $display("FAIL single_counters got=%0d/%b exp=1/0", load_words, load_err); end
    n_cmp++; if (bus.IAXI_read_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_hold got=%h exp=deadbeef", bus.IAXI_read_data); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, rd; int lat, pul, busy; bit st, re, tmo;
    xfer(32'h0000_0040, 32'h1234_5678, 5, 4, 2'b00, 1'b1, 4'h0, 0, a, lat, pul, rd, st, busy, re, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL bp_timeout got=timeout exp=pulse"); end
    n_cmp++; if (a !== 32'h2000_0040 || st !== 1'b1) begin n_bad++; $display("FAIL bp_araddr got=%h stable%b exp=20000040 stable1", a, st); end
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL bp_latency got=%0d exp=12", lat); end
    n_cmp++; if (pul !== 1 || rd !== 32'h1234_5678) begin n_bad++; $display("FAIL bp_data got=%0d/%h exp=1/12345678", pul, rd); end
    n_cmp++; if (busy !== 0 || re !== 1'b1) begin n_bad++; $display("FAIL bp_ready got=busy%0d end%b exp=busy0 end1", busy, re); end
    n_cmp++; if (load_words !== 16'd2) begin n_bad++; $display("FAIL bp_words got=%0d exp=2", load_words); end
  endtask

  task automatic test_full_load();
    logic [31:0] a, rd, ea, ed; int lat, pul, busy; bit st, re, tmo;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      ea = 32'h2000_0000 + 32'(i * 4);
      ed = 32'hC0DE_0000 + 32'(i);
      xfer(32'(i * 4), ed, ar_tab[i], r_tab[i], 2'b00, 1'b1, 4'h0, 0, a, lat, pul, rd, st, busy, re, tmo);
      n_cmp++; if (a !== ea || rd !== ed || pul !== 1 || tmo || !st)
        begin n_bad++; $display("FAIL full_word%0d got=%h/%h/%0d exp=%h/%h/1", i, a, rd, pul, ea, ed); end
    end
    n_cmp++; if (load_words !== 16'd8 || load_err !== 1'b0) begin n_bad++; $display("FAIL full_counters got=%0d/%b exp=8/0", load_words, load_err); end
  endtask

  task automatic test_error();
    logic [31:0] a, rd; int lat, pul, busy; bit st, re, tmo;
    logic [1:0] rr; logic exp_err;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      rr      = (i == 3) ? 2'b10 : 2'b00;
      exp_err = (i >= 3);
      xfer(32'h0000_0100 + 32'(i * 4), 32'h5A00_0000 + 32'(i), 1, 0, rr, 1'b1, 4'h0, 0, a, lat, pul, rd, st, busy, re, tmo);
      n_cmp++; if (load_err !== exp_err || rd !== 32'h5A00_0000 + 32'(i) || tmo)
        begin n_bad++; $display("FAIL err_word%0d got=err%b rd%h exp=err%b rd%h", i, load_err, rd, exp_err, 32'h5A00_0000 + 32'(i)); end
    end
    n_cmp++; if (load_words !== 16'd5) begin n_bad++; $display("FAIL err_words got=%0d exp=5", load_words); end
  endtask

  task automatic test_protocol();
    logic [31:0] a, rd; int lat, pul, busy; bit st, re, tmo;
    apply_reset();
    xfer(32'h0000_0023, 32'h0BAD_F00D, 0, 0, 2'b00, 1'b0, 4'h0, 0, a, lat, pul, rd, st, busy, re, tmo);
    n_cmp++; if (a !== 32'h2000_0020) begin n_bad++; $display("FAIL align_araddr got=%h exp=20000020", a); end
    n_cmp++; if (load_err !== 1'b1 || rd !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL rlast_err got=%b/%h exp=1/0badf00d", load_err, rd); end
    apply_reset();
    xfer(32'hF000_0000, 32'h7777_0001, 0, 0, 2'b00, 1'b1, 4'h3, 0, a, lat, pul, rd, st, busy, re, tmo);
    n_cmp++; if (a !== 32'h1000_0000) begin n_bad++; $display("FAIL wrap_araddr got=%h exp=10000000", a); end
    n_cmp++; if (load_err !== 1'b1 || rd !== 32'h7777_0001) begin n_bad++; $display("FAIL rid_err got=%b/%h exp=1/77770001", load_err, rd); end
  endtask

  task automatic test_window_close();
    logic [31:0] a, rd; int lat, pul, busy; bit st, re, tmo; bit bad;
    apply_reset();
    xfer(32'h0000_0080, 32'hFACE_0080, 0, 2, 2'b00, 1'b1, 4'h0, 1, a, lat, pul, rd, st, busy, re, tmo);
    n_cmp++; if (pul !== 1 || rd !== 32'hFACE_0080 || tmo) begin n_bad++; $display("FAIL win_pulse got=%0d/%h exp=1/face0080", pul, rd); end
    n_cmp++; if (re !== 1'b0) begin n_bad++; $display("FAIL win_ready got=%b exp=0", re); end
    bad = 0;
    bus.itcm_access_AXI = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ARVALID !== 1'b0 || bus.IAXI_ready !== 1'b0) bad = 1;
    end
    bus.itcm_access_AXI = 1'b0;
    n_cmp++; if (bad) begin n_bad++; $display("FAIL win_no_ar got=issued exp=none"); end
    n_cmp++; if (load_words !== 16'd1) begin n_bad++; $display("FAIL win_words got=%0d exp=1", load_words); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, rd; int lat, pul, busy; bit st, re, tmo;
    apply_reset();
    xfer(32'h0000_0000, 32'h1111_1111, 0, 0, 2'b00, 1'b1, 4'h0, 0, a, lat, pul, rd, st, busy, re, tmo);
    bus.itcm_auto_load_addr = 32'h0000_0008;
    bus.itcm_access_AXI     = 1'b1;
    bus.ARREADY             = 1'b0;
    @(negedge clk);
    bus.itcm_access_AXI = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ARVALID !== 1'b1) begin n_bad++; $display("FAIL mid_arvalid_pre got=%b exp=1", bus.ARVALID); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (bus.ARVALID !== 1'b0 || bus.IAXI_ready !== 1'b0 || load_words !== 16'd0)
      begin n_bad++; $display("FAIL mid_reset got=arv%b rdy%b words%0d exp=0/0/0", bus.ARVALID, bus.IAXI_ready, load_words); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.IAXI_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_after got=%b exp=1", bus.IAXI_ready); end
    xfer(32'h0000_0004, 32'h2222_2222, 0, 0, 2'b00, 1'b1, 4'h0, 0, a, lat, pul, rd, st, busy, re, tmo);
    n_cmp++; if (a !== 32'h2000_0004 || rd !== 32'h2222_2222 || lat !== 3 || load_words !== 16'd1)
      begin n_bad++; $display("FAIL mid_fresh got=%h/%h/%0d/%0d exp=20000004/22222222/3/1", a, rd, lat, load_words); end
  endtask

  initial begin
    idle_inputs();
    bus.itcm_auto_load = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_full_load();
    test_error();
    test_protocol();
    test_window_close();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
